// File: rtl/jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// jk_bank_ctrl : command sequencer driving the J/K lines of a JK flip-flop bank
// Optional feature macro: JKCTRL_ABORT_EN (adds the abort input)
// Revision : 1.0
// ============================================================================
module jk_bank_ctrl #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
`ifdef JKCTRL_ABORT_EN
  input  logic              abort,
`endif
  input  logic [WIDTH-1:0]  q_in,
  output logic [WIDTH-1:0]  j_out,
  output logic [WIDTH-1:0]  k_out,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              wrap,
  output logic              cmd_err
);

  localparam logic [2:0] c_op_hold   = 3'd0;
  localparam logic [2:0] c_op_clear  = 3'd1;
  localparam logic [2:0] c_op_set    = 3'd2;
  localparam logic [2:0] c_op_load   = 3'd3;
  localparam logic [2:0] c_op_toggle = 3'd4;
  localparam logic [2:0] c_op_cnt_up = 3'd5;
  localparam logic [2:0] c_op_cnt_dn = 3'd6;
  localparam logic [2:0] c_op_rsvd   = 3'd7;

  localparam logic [STEP_W-1:0] c_step_one = {{(STEP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_COUNT  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                wrap_q, wrap_d;

  logic [WIDTH-1:0]    up_mask;
  logic [WIDTH-1:0]    dn_mask;
  logic                abort_req;

`ifdef JKCTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Ripple-carry style enables: a bit toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    up_mask    = '0;
    dn_mask    = '0;
    up_mask[0] = 1'b1;
    dn_mask[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_mask[i] = up_mask[i-1] & q_in[i-1];
      dn_mask[i] = dn_mask[i-1] & ~q_in[i-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    steps_d   = steps_q;
    wrap_d    = wrap_q;
    j_out     = '0;
    k_out     = '0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    result    = '0;
    wrap      = 1'b0;
    cmd_err   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          steps_d = cmd_steps;
          wrap_d  = 1'b0;
          if ((cmd_op == c_op_cnt_up) || (cmd_op == c_op_cnt_dn)) begin
            state_d = (cmd_steps != '0) ? ST_COUNT : ST_REPORT;
          end else begin
            state_d = ST_APPLY;
          end
        end
      end

      ST_APPLY: begin
        unique case (op_q)
          c_op_clear:  k_out = '1;
          c_op_set:    j_out = '1;
          c_op_load: begin
            j_out = data_q;
            k_out = ~data_q;
          end
          c_op_toggle: begin
            j_out = data_q;
            k_out = data_q;
          end
          default: ;
        endcase
        state_d = ST_REPORT;
      end

      ST_COUNT: begin
        if (abort_req) begin
          state_d = ST_REPORT;
        end else begin
          if (op_q == c_op_cnt_up) begin
            j_out = up_mask;
            k_out = up_mask;
            if (q_in == '1) wrap_d = 1'b1;
          end else begin
            j_out = dn_mask;
            k_out = dn_mask;
            if (q_in == '0) wrap_d = 1'b1;
          end
          steps_d = steps_q - c_step_one;
          if (steps_q <= c_step_one) state_d = ST_REPORT;
        end
      end

      ST_REPORT: begin
        done    = 1'b1;
        result  = q_in;
        wrap    = wrap_q;
        cmd_err = (op_q == c_op_rsvd);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= c_op_hold;
      data_q  <= '0;
      steps_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      steps_q <= steps_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// tb_jk_bank_ctrl : randomized bench for jk_bank_ctrl with a JK bank and an
// arithmetic reference model of the bank contents.
// Revision : 1.0
// ============================================================================
module tb_jk_bank_ctrl;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 8;
  localparam int MODV   = 1 << WIDTH;
  localparam int ALL1   = MODV - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = '0;
  logic [WIDTH-1:0]  cmd_data = '0;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic [WIDTH-1:0]  bank_q;
  logic [WIDTH-1:0]  j_out, k_out, result;
  logic              busy, done, wrap, cmd_err;
`ifdef JKCTRL_ABORT_EN
  logic              abort = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int q_exp    = 0;

  always #5 clock = ~clock;

  jk_bank_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_steps (cmd_steps),
`ifdef JKCTRL_ABORT_EN
    .abort     (abort),
`endif
    .q_in      (bank_q),
    .j_out     (j_out),
    .k_out     (k_out),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .wrap      (wrap),
    .cmd_err   (cmd_err)
  );

  // The JK storage bank sharing clock and reset with the controller
  always_ff @(posedge clock or posedge reset) begin
    if (reset) bank_q <= '0;
    else       bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic run_cmd(input int op, input int data, input int steps,
                         input int abort_at, input bit hold_load);
    int  q0, eff, lat, r_exp, cyc, t;
    bit  w_exp, is_cnt, hs_bad;
    int  j_exp, k_exp;
    q0     = q_exp;
    is_cnt = (op == 5) || (op == 6);
    eff    = steps;
    lat    = 2;
    if (is_cnt) begin
      if (abort_at >= 1 && abort_at <= steps) begin
        eff = abort_at - 1;
        lat = abort_at + 1;
      end else begin
        lat = steps + 1;
      end
    end
    w_exp = 1'b0;
    j_exp = 0;
    k_exp = 0;
    case (op)
      1: begin r_exp = 0;     k_exp = ALL1; end
      2: begin r_exp = ALL1;  j_exp = ALL1; end
      3: begin r_exp = data;  j_exp = data; k_exp = ALL1 - data; end
      4: begin r_exp = q0 ^ data; j_exp = data; k_exp = data; end
      5: begin r_exp = (q0 + eff) % MODV; w_exp = (q0 + eff) >= MODV; end
      6: begin r_exp = (((q0 - eff) % MODV) + MODV) % MODV; w_exp = eff > q0; end
      default: r_exp = q0;
    endcase

    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_data  = WIDTH'(data);
    cmd_steps = STEP_W'(steps);
    @(negedge clock);
    cyc = 1;
    if (hold_load) begin
      cmd_op   = 3'd3;
      cmd_data = 4'b0011;
    end else begin
      cmd_valid = 1'b0;
    end

    hs_bad = 1'b0;
    while (!done && cyc < 300) begin
      if (cmd_ready || !busy) hs_bad = 1'b1;
      if (cyc == 1 && !is_cnt) begin
        check("apply_j", 32'(j_out), 32'(j_exp));
        check("apply_k", 32'(k_out), 32'(k_exp));
      end
`ifdef JKCTRL_ABORT_EN
      abort = (cyc == abort_at);
`endif
      @(negedge clock);
      cyc++;
    end
`ifdef JKCTRL_ABORT_EN
    abort = 1'b0;
`endif
    check("latency", 32'(cyc), 32'(lat));
    check("handshake_busy", 32'(hs_bad), 32'd0);
    check("report_ready_busy", {30'd0, cmd_ready, busy}, 32'd1);
    check("result", 32'(result), 32'(r_exp));
    check("wrap", 32'(wrap), 32'(w_exp));
    check("cmd_err", 32'(cmd_err), 32'(op == 7));
    check("report_jk", {j_out, k_out}, 32'd0);
    q_exp = r_exp;
  endtask

  initial begin
    int op, data, steps, ab, gap;
    bit saw_done;

    repeat (2) @(negedge clock);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy_done", {busy, done, wrap, cmd_err}, 32'd0);
    check("rst_jk", {j_out, k_out}, 32'd0);
    check("rst_bank", 32'(bank_q), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_cmd(3, 4'b1010, 0, 0, 0);
    run_cmd(4, 4'b0110, 0, 0, 0);
    run_cmd(1, 0, 0, 0, 0);
    run_cmd(2, 0, 0, 0, 0);
    run_cmd(1, 0, 0, 0, 0);
    run_cmd(5, 0, 5, 0, 0);
    run_cmd(5, 0, 12, 0, 0);
    run_cmd(6, 0, 3, 0, 0);
    run_cmd(6, 0, 0, 0, 0);
    run_cmd(5, 0, 4, 0, 1);
    run_cmd(3, 4'b0011, 0, 0, 0);
    run_cmd(7, 4'b1111, 0, 0, 0);
`ifdef JKCTRL_ABORT_EN
    run_cmd(1, 0, 0, 0, 0);
    run_cmd(5, 0, 8, 2, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      op    = int'($urandom_range(0, 7));
      data  = int'($urandom_range(0, ALL1));
      steps = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
      ab    = 0;
`ifdef JKCTRL_ABORT_EN
      if ((op == 5 || op == 6) && steps > 0 && $urandom_range(0, 2) == 0)
        ab = int'($urandom_range(1, steps));
`endif
      run_cmd(op, data, steps, ab, 0);
      check("bank_tracks_model", 32'(bank_q), 32'(q_exp));
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clock);
    end

    // Reset during the third COUNT cycle aborts with no done pulse
    run_cmd(1, 0, 0, 0, 0);
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    cmd_steps = 8'd8;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_jk", {j_out, k_out}, 32'd0);
    check("rst_mid_busy_ready", {30'd0, busy, cmd_ready}, 32'd1);
    check("rst_mid_bank", 32'(bank_q), 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c == 2) reset = 1'b0;
      if (done) saw_done = 1'b1;
    end
    check("rst_mid_no_done", 32'(saw_done), 32'd0);
    q_exp = 0;
    run_cmd(5, 0, 2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
Command sequencer for a WIDTH-bit bank of the team's JK flip-flops. The bank shares this block's clock and reset. The block accepts one command at a time over a valid/ready handshake and drives per-bit J/K lines to clear, set, load, toggle or count the bank. It reads the bank's q back to compute the count drive and to report the result. It sits between the register-file/control logic and the JK storage bank.

Parameters:
WIDTH, 4, number of JK flip-flops in the bank
STEP_W, 8, width of the count step field

Ports:
clock  input  1  rising-edge clock, shared with the bank
reset  input  1  asynchronous, active-high; shared with the bank
cmd_valid  input  1  command offered
cmd_ready  output  1  block can accept a command
cmd_op  input  3  0 HOLD, 1 CLEAR, 2 SET, 3 LOAD, 4 TOGGLE, 5 CNT_UP, 6 CNT_DN, 7 reserved
cmd_data  input  WIDTH  load value or toggle mask
cmd_steps  input  STEP_W  count steps for CNT_UP/CNT_DN
q_in  input  WIDTH  bank q outputs
j_out  output  WIDTH  bank J inputs
k_out  output  WIDTH  bank K inputs
busy  output  1  command in progress
done  output  1  one-cycle pulse, command complete
result  output  WIDTH  bank value, valid while done=1
wrap  output  1  valid with done; a count step crossed the wrap boundary
cmd_err  output  1  one-cycle pulse with done for op 7

Behaviour:
- Reset (asynchronous): state IDLE; j_out=k_out=0; done=wrap=cmd_err=0; busy=0; cmd_ready=1; internal op/data/step registers cleared. The bank clears to q=0 on the same reset.
- Reset mid-command aborts the command immediately. No done is issued.
- Handshake: a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1. cmd_ready=1 only in IDLE. cmd_op, cmd_data and cmd_steps are latched at acceptance and ignored thereafter.
- States: IDLE, APPLY, COUNT, REPORT.
- IDLE:
  - j_out=k_out=0, so the bank holds.
  - On acceptance:
    - ops 0-4 and 7 go to APPLY.
    - ops 5/6 go to COUNT if steps!=0, else to REPORT.
- APPLY (exactly 1 cycle), j/k drive by op:
  - HOLD: j=0, k=0
  - CLEAR: j=0, k=all1
  - SET: j=all1, k=0
  - LOAD: j=data, k=~data
  - TOGGLE: j=k=data
  - op 7: j=k=0
  - The bank updates on the next edge; the state goes to REPORT on that edge.
- COUNT:
  - j_out/k_out are combinational from q_in.
  - CNT_UP: bit i gets j=k=AND(q_in[i-1:0]); bit 0 = 1.
  - CNT_DN: bit i gets j=k=AND(~q_in[i-1:0]); bit 0 = 1.
  - Exactly one bank step per cycle. The remaining-step counter decrements each cycle.
  - After the cycle with remaining=1, go to REPORT.
  - Wrap flag: set in any COUNT cycle where UP and q_in=all1, or DN and q_in=0. The flag is cleared at acceptance.
- REPORT (exactly 1 cycle):
  - j=k=0; done=1; result=q_in; wrap=flag; cmd_err=1 only for op 7.
  - Next state IDLE.
- busy=1 in APPLY, COUNT and REPORT.
- Latency from acceptance edge to done:
  - ops 0-4 and 7: done asserted in the 2nd cycle.
  - count with S steps: done in cycle S+1.
  - count with S=0: done in cycle 1, bank untouched.
- Counting wraps modulo 2^WIDTH: UP from all1 gives 0; DN from 0 gives all1.
- A new command can be accepted in the cycle after REPORT, at the earliest.

Optional Feature:
JKCTRL_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 sampled in COUNT makes j=k=0 combinationally in that same cycle, so no step is taken, and the state goes to REPORT on the next edge.
  - done, result and wrap are reported as normal for the steps already taken.
  - abort is ignored in all other states.
- Undefined: the port is absent and COUNT always runs all steps.

Test Plan:
1. Reset, then LOAD data=4'b1010 → j_out=1010, k_out=0101 during APPLY; done with result=1010, wrap=0, cmd_err=0.
2. From 1010: TOGGLE data=4'b0110 → result=1100. Then CLEAR → result=0000. Then SET → result=1111.
3. From 0000: CNT_UP steps=5 → done exactly 6 cycles after acceptance, result=0101, wrap=0. Then CNT_UP steps=12 → result=0001, wrap=1.
4. From 0001: CNT_DN steps=3 → result=1110, wrap=1. Then CNT_DN steps=0 → done in next cycle, result=1110, j/k stay 0.
5. cmd_valid held high with op=LOAD 0011 during a CNT_UP → cmd_ready=0 until IDLE, and the second command is accepted only after done. Op 7 → cmd_err pulse, bank unchanged.
6. Assert reset during the 3rd COUNT cycle → j_out=k_out=0, busy=0, cmd_ready=1 and q_in=0 immediately, with no done pulse. With JKCTRL_ABORT_EN: abort in the 2nd COUNT cycle of CNT_UP steps=8 from 0000 → result=0001.
